alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered result stage directly downstream of the 16-bit 74181-style ALU. It captures the ALU result `y` and carry-out `co` with the destination register tag, derives status flags, and buffers up to two results in a skid FIFO toward register-file writeback. Upstream and downstream use valid/ready handshakes, so writeback back-pressure never drops an ALU result.

## Interface
- `DEPTH`, default 2: FIFO entries; legal values are 2 and 4.
- `TAG_W`, default 3: width of the destination register tag.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: ALU result is valid this cycle.
- `in_ready` output, 1 bit: stage can accept a result.
- `in_y` input, 16 bits: ALU result.
- `in_co` input, 1 bit: ALU carry-out.
- `in_tag` input, `TAG_W` bits: destination register.
- `in_wr_flags` input, 1 bit: this result updates the architectural flags.
- `out_valid` output, 1 bit: head entry is valid.
- `out_ready` input, 1 bit: writeback consumes the head entry.
- `out_data` output, 16 bits: head result.
- `out_tag` output, `TAG_W` bits: head destination.
- `out_flags` output, 4 bits: head entry flags `{P,N,C,Z}` (bit 0 = Z).
- `flags` output, 4 bits: architectural flags register `{P,N,C,Z}`.
- `count` output, `$clog2(DEPTH)+1` bits: occupancy.

## Operation
- Accept occurs when `in_valid & in_ready`. The stage pushes `{in_y, in_tag, fl}` at the write pointer.
  - `fl.Z = (in_y == 0)`
  - `fl.C = in_co`
  - `fl.N = in_y[15]`
  - `fl.P = ^in_y` (odd parity; gated by the macro below)
- Pop occurs when `out_valid & out_ready`. The read pointer advances.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. Occupancy is tracked by `count`, which is never inferred from pointer equality.
- State per cycle:
  - EMPTY (`count==0`): push only.
  - PARTIAL: push and/or pop. Simultaneous push and pop leaves `count` unchanged.
  - FULL (`count==DEPTH`): pop only.
- `in_ready = (count != DEPTH)`. This is combinational from registered `count` only, with no path from `out_ready`. In FULL, a same-cycle pop does not enable a push.
- `out_valid = (count != 0)`. `out_data`, `out_tag` and `out_flags` are driven from the head entry.
- `flags` loads `fl` on an accept with `in_wr_flags=1`. Otherwise it holds. It is independent of pops.
- `in_valid=1` while `in_ready=0` has no effect. Upstream holds its data.
- Entries with `in_wr_flags=0` still carry their computed `fl` in `out_flags`.

## Timing
- Latency from accept to `out_valid` is 1 cycle. The data appears on the clock edge after acceptance, whether the FIFO was empty or not, once the entry reaches the head.
- Throughput is 1 result per cycle while `out_ready=1` continuously.
- `flags` updates on the accept edge and is visible the next cycle.
- Reset is asynchronous on `rst_n` falling and is released synchronously by the design upstream. Reset values:
  - `count=0`, both pointers 0.
  - `out_valid=0`, `in_ready=1`.
  - `out_data=0`, `out_tag=0`, `out_flags=0`, `flags=0`. Storage for all entries is cleared.
- Reset mid-operation discards all buffered entries. The first accept after reset lands in entry 0.
- `out_*` are stable while `out_valid=1 & out_ready=0`.

## Configuration
- `ALU_RES_PARITY_EN`:
  - Defined: `fl.P = ^in_y` and is stored and propagated to `out_flags[3]` and `flags[3]`.
  - Undefined: bit 3 is tied to 0 everywhere and no parity storage is built. All other behaviour is identical.

## Test plan
- Reset and single result:
  - During reset: `out_valid=0`, `in_ready=1`, `flags=0`.
  - Stimulus: push `y=16'h0000`, `co=1`, `tag=3`, `wr_flags=1`.
  - Next cycle: `out_data=0`, `out_tag=3`, `out_flags=4'b0011`, `flags=4'b0011`.
- Fill with `DEPTH=2` and `out_ready=0`:
  - Push `16'h8001`, then `16'h1234`.
  - `count=2` and `in_ready=0`. A third push of `16'hFFFF` is ignored.
  - Drain with `out_ready=1`: the stage outputs `8001`, then `1234`, then `out_valid=0`.
- Simultaneous push and pop at `count=1`:
  - `count` stays 1.
  - Order is preserved across pointer wrap for 10 consecutive results `16'h0001` through `16'h000A`.
- Flags gating:
  - Push `16'h8000` with `wr_flags=1`, then `16'h0000` with `wr_flags=0`.
  - `flags` is `N=1`, `Z=0`.
  - The second entry shows `out_flags.Z=1`.
- Parity:
  - With `ALU_RES_PARITY_EN` defined, `y=16'h0007` gives `out_flags[3]=1`.
  - Without the macro, `out_flags[3]=0`.
- Mid-operation reset:
  - Stimulus: `count=2`, then `rst_n` pulses low between clock edges.
  - Immediately: `out_valid=0`, `count=0`.
  - After release, a push of `16'h00AA` appears as the head the next cycle.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: derives {P,N,C,Z}, holds an architectural flags register
// and buffers results in a small FIFO toward writeback. Parity is built only when ALU_RES_PARITY_EN is defined.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_y,
    input  logic                     in_co,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_wr_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags,
    output logic [3:0]               flags,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // in_ready depends only on registered occupancy; a producer holds its data until accepted.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t          state;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_nxt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [2:0]      fl_ncz;
    logic [2:0]      flags_ncz;

    logic [15:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [2:0]       ncz_mem  [DEPTH];

    // {N,C,Z}; parity is handled separately so it can be compiled out.
    assign fl_ncz = {in_y[15], in_co, (in_y == 16'h0000)};

    always_comb begin
        state = ST_PARTIAL;
        if (count == '0) begin
            state = ST_EMPTY;
        end else if (count == CW'(DEPTH)) begin
            state = ST_FULL;
        end
    end

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        count_nxt = count;
        case (state)
            ST_EMPTY:   push = in_valid;
            ST_PARTIAL: begin
                push = in_valid;
                pop  = out_ready;
            end
            ST_FULL:    pop = out_ready;
            default:    ;
        endcase
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
                ncz_mem[i]  <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= in_y;
            tag_mem[wr_ptr]  <= in_tag;
            ncz_mem[wr_ptr]  <= fl_ncz;
        end
    end

    // Architectural flags follow accepts only; pops never touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_ncz <= '0;
        end else if (push && in_wr_flags) begin
            flags_ncz <= fl_ncz;
        end
    end

    assign out_data = data_mem[rd_ptr];
    assign out_tag  = tag_mem[rd_ptr];

`ifdef ALU_RES_PARITY_EN
    logic par_mem [DEPTH];
    logic flags_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_mem[i] <= 1'b0;
            end
            flags_p <= 1'b0;
        end else if (push) begin
            par_mem[wr_ptr] <= ^in_y;
            if (in_wr_flags) begin
                flags_p <= ^in_y;
            end
        end
    end

    assign out_flags = {par_mem[rd_ptr], ncz_mem[rd_ptr]};
    assign flags     = {flags_p, flags_ncz};
`else
    assign out_flags = {1'b0, ncz_mem[rd_ptr]};
    assign flags     = {1'b0, flags_ncz};
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed cases plus random traffic against a queue model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int TAG_W = 3;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int W     = 16 + TAG_W + 4;
`ifdef ALU_RES_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_y = '0;
    logic             in_co = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_wr_flags = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;
    logic [3:0]       flags;
    logic [CW-1:0]    count;

    // clock / reset
    always #5 clk = ~clk;

    alu_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_co(in_co),
        .in_tag(in_tag), .in_wr_flags(in_wr_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_flags(out_flags), .flags(flags), .count(count)
    );

    // scoreboard: entries packed as {y, tag, fl}
    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_flags = '0;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_fl(input logic [15:0] y, input logic co);
        logic p;
        p = PAR_EN ? ^y : 1'b0;
        return {p, y[15], co, (y == 16'h0000)};
    endfunction

    task automatic check_outputs();
        logic [W-1:0] head;
        check("count", 32'(count), exp_q.size());
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        check("flags", 32'(flags), 32'(exp_flags));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_data", 32'(out_data), 32'(head[W-1 -: 16]));
            check("out_tag", 32'(out_tag), 32'(head[4 +: TAG_W]));
            check("out_flags", 32'(out_flags), 32'(head[3:0]));
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic [15:0] y, input logic co,
                         input logic [TAG_W-1:0] tag, input logic wf, input logic ordy);
        in_valid    = v;
        in_y        = y;
        in_co       = co;
        in_tag      = tag;
        in_wr_flags = wf;
        out_ready   = ordy;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 16'h0000, 1'b0, '0, 1'b0, ordy);
    endtask

    // check at negedge, then advance the model across the next rising edge
    task automatic tick();
        logic         acc;
        logic         pp;
        logic         wf;
        logic [W-1:0] ent;
        @(negedge clk);
        check_outputs();
        acc = in_valid && (exp_q.size() != DEPTH);
        pp  = out_ready && (exp_q.size() != 0);
        ent = {in_y, in_tag, model_fl(in_y, in_co)};
        wf  = in_wr_flags;
        @(posedge clk);
        #1;
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(ent);
            if (wf) exp_flags = ent[3:0];
        end
    endtask

    initial begin
        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single result
        drive(1'b1, 16'h0000, 1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        idle(1'b0);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'd0);
        check("single_out_tag", 32'(out_tag), 32'd3);
        check("single_out_flags", 32'(out_flags), 32'b0011);
        check("single_flags", 32'(flags), 32'b0011);
        idle(1'b1);
        tick();

        // fill, ignored third push, drain
        drive(1'b1, 16'h8001, 1'b0, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h1234, 1'b0, 3'd2, 1'b0, 1'b0);
        tick();
        check("fill_count", 32'(count), 32'd2);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'hFFFF, 1'b1, 3'd7, 1'b1, 1'b0);
        tick();
        check("fill_head_kept", 32'(out_data), 32'h8001);
        check("fill_flags_kept", 32'(flags), 32'b0011);
        idle(1'b1);
        tick();
        check("drain_second", 32'(out_data), 32'h1234);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        // simultaneous push/pop at count=1 across pointer wrap
        drive(1'b1, 16'h0001, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 2; i <= 10; i++) begin
            drive(1'b1, 16'(i), 1'b0, TAG_W'(i), 1'b0, 1'b1);
            tick();
            check("pp_count", 32'(count), 32'd1);
            check("pp_order", 32'(out_data), 32'(i));
        end
        idle(1'b1);
        tick();
        check("pp_drained", 32'(out_valid), 32'd0);

        // flags gating
        drive(1'b1, 16'h8000, 1'b0, 3'd4, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0000, 1'b0, 3'd5, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        check("gate_flags_n", 32'(flags[2]), 32'd1);
        check("gate_flags_z", 32'(flags[0]), 32'd0);
        tick();
        check("gate_second_z", 32'(out_flags[0]), 32'd1);
        tick();

        // parity
        drive(1'b1, 16'h0007, 1'b0, 3'd6, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        check("parity_out_flag", 32'(out_flags[3]), 32'(PAR_EN));
        check("parity_arch_flag", 32'(flags[3]), 32'(PAR_EN));
        tick();

        // mid-operation reset
        drive(1'b1, 16'h0101, 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0202, 1'b0, 3'd2, 1'b1, 1'b0);
        tick();
        check("mr_count_before", 32'(count), 32'd2);
        idle(1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_flags", 32'(flags), 32'd0);
        exp_q.delete();
        exp_flags = '0;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 16'h00AA, 1'b0, 3'd2, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        check("mr_push_valid", 32'(out_valid), 32'd1);
        check("mr_push_data", 32'(out_data), 32'h00AA);
        idle(1'b1);
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                  TAG_W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 9) == 0) in_y = 16'h0000;
            tick();
        end
        idle(1'b1);
        for (int i = 0; i < DEPTH + 1; i++) tick();
        check("final_empty", 32'(out_valid), 32'd0);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
